// File: rtl/output_ram_unpacker.sv
// ---------------------------------------------------------------------------
// output_ram_unpacker
//
// Reads N words (N = i_count, clamped to DEPTH) from the 64-bit output RAM in
// address order, splits each word into two 32-bit beats and streams them out
// on a valid/ready interface.  A one-cycle o_done pulse marks the end of the
// transfer.  i_count == 0 completes immediately with only the done pulse.
//
// Ports:
//   i_clk, i_reset_n : clock, synchronous active-low reset
//   i_start, i_count : transfer request and word count (sampled together)
//   o_addr_r, o_read : RAM read address / enable (RAM data is combinational)
//   i_rdata          : RAM read data
//   o_data, o_valid  : output beat stream
//   i_ready          : sink ready
//   o_busy, o_done   : transfer in progress / completion pulse
//
// Handshake: a beat moves only when o_valid and i_ready are both high at a
// rising edge.  o_valid and o_data are decoded from registered state only, so
// they never depend combinationally on i_ready and remain stable while the
// sink stalls.
//
// Optional feature (macro OUTPUT_RAM_UNPACK_SWAP_EN): when defined, each word
// is emitted upper half first.  Timing and handshake are identical.
// ---------------------------------------------------------------------------
module output_ram_unpacker #(
  parameter int DEPTH  = 5,
  parameter int IN_W   = 64,
  parameter int OUT_W  = 32,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 3
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_start,
  input  logic [CNT_W-1:0]  i_count,
  output logic [ADDR_W-1:0] o_addr_r,
  output logic              o_read,
  input  logic [IN_W-1:0]   i_rdata,
  output logic [OUT_W-1:0]  o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_busy,
  output logic              o_done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LO    = 3'd2,
    S_HI    = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  state_t             r_state;
  state_t             w_next_state;
  logic [IN_W-1:0]    r_hold;
  logic [CNT_W-1:0]   r_remaining;
  logic [ADDR_W-1:0]  r_addr;

  logic [CNT_W-1:0]   w_count_clamped;
  logic               w_accept;
  logic [OUT_W-1:0]   w_first_half;
  logic [OUT_W-1:0]   w_second_half;

  assign w_count_clamped = (i_count > DEPTH_C) ? DEPTH_C : i_count;
  // o_valid is a pure state decode, so this adds no path from i_ready to o_valid.
  assign w_accept        = o_valid & i_ready;

`ifdef OUTPUT_RAM_UNPACK_SWAP_EN
  assign w_first_half  = r_hold[IN_W-1:OUT_W];
  assign w_second_half = r_hold[OUT_W-1:0];
`else
  assign w_first_half  = r_hold[OUT_W-1:0];
  assign w_second_half = r_hold[IN_W-1:OUT_W];
`endif

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next_state = (i_count == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: w_next_state = S_LO;
      S_LO: begin
        if (w_accept) w_next_state = S_HI;
      end
      S_HI: begin
        if (w_accept) begin
          w_next_state = (r_remaining > CNT_W'(1)) ? S_FETCH : S_DONE;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Outputs decoded from the current state only
  always_comb begin
    o_read   = 1'b0;
    o_addr_r = '0;
    o_valid  = 1'b0;
    o_data   = '0;
    o_busy   = 1'b0;
    o_done   = 1'b0;
    case (r_state)
      S_FETCH: begin
        o_read   = 1'b1;
        o_addr_r = r_addr;
        o_busy   = 1'b1;
      end
      S_LO: begin
        o_valid = 1'b1;
        o_data  = w_first_half;
        o_busy  = 1'b1;
      end
      S_HI: begin
        o_valid = 1'b1;
        o_data  = w_second_half;
        o_busy  = 1'b1;
      end
      S_DONE: begin
        o_busy = 1'b1;
        o_done = 1'b1;
      end
      default: ;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state     <= S_IDLE;
      r_hold      <= '0;
      r_remaining <= '0;
      r_addr      <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          // i_start is only honoured here, so a request while busy or in the
          // done cycle leaves the latched count and address untouched.
          if (i_start && (i_count != '0)) begin
            r_remaining <= w_count_clamped;
            r_addr      <= '0;
          end
        end
        S_FETCH: r_hold <= i_rdata;
        S_HI: begin
          if (w_accept) begin
            if (r_remaining > CNT_W'(1)) begin
              r_remaining <= r_remaining - CNT_W'(1);
              r_addr      <= r_addr + ADDR_W'(1);
            end else begin
              r_remaining <= '0;
              r_addr      <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
